// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: asserts all reset outputs together, then releases them
// in staggered order after an external, debounced-button or software reset request.
module reset_sequencer #(
  parameter int unsigned NUM_CHANNELS    = 3,
  parameter int unsigned HOLD_CYCLES     = 10,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_button_n,
  input  logic                    i_sw_reset,
  output logic [NUM_CHANNELS-1:0] o_reset_n,
  output logic                    o_busy,
  output logic [1:0]              o_cause
);

  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CHANNELS - 1);

  localparam logic [1:0] CAUSE_EXT    = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SW     = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  logic [SYNC_STAGES-1:0]  rst_chain;
  logic [SYNC_STAGES-1:0]  btn_chain;
  logic                    rst_sync;
  logic                    btn_sync;
  logic                    db_level;
  logic [CNT_WIDTH-1:0]    db_cnt;
  logic                    db_diff;
  logic                    db_done;
  logic                    press;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [NUM_CHANNELS-1:0] rst_q, rst_d;
  logic                    busy_q, busy_d;
  logic [1:0]              cause_q, cause_d;

  // Reset deassertion synchroniser and button synchroniser
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rst_chain <= '0;
      btn_chain <= '1;
    end else begin
      rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b1};
      btn_chain <= {btn_chain[SYNC_STAGES-2:0], i_button_n};
    end
  end

  assign rst_sync = rst_chain[SYNC_STAGES-1];
  assign btn_sync = btn_chain[SYNC_STAGES-1];

  // Debounce: level flips after DEBOUNCE_CYCLES consecutive differing samples
  assign db_diff = (btn_sync != db_level);
  assign db_done = db_diff && (db_cnt == DEB_LAST);
  assign press   = db_done && db_level;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else if (!db_diff) begin
      db_cnt <= '0;
    end else if (db_done) begin
      db_level <= btn_sync;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_WIDTH'(1);
    end
  end

  // Sequencer state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rst_q   <= rst_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic; a reset request overrides the sequence in any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rst_d   = rst_q;
    busy_d  = busy_q;
    cause_d = cause_q;

    if (press || i_sw_reset) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      ch_d    = '0;
      rst_d   = '0;
      busy_d  = 1'b1;
      cause_d = press ? CAUSE_BUTTON : CAUSE_SW;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!rst_sync || !db_level) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            cnt_d    = '0;
            rst_d[0] = 1'b1;
            ch_d     = CH_W'(1);
            if (NUM_CHANNELS == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d       = '0;
            rst_d[ch_q] = 1'b1;
            ch_d        = ch_q + CH_W'(1);
            if (ch_q == LAST_CH) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign o_reset_n = rst_q;
  assign o_busy    = busy_q;
  assign o_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: checkpoint table plus hand-written corner sequences.
module tb_reset_sequencer;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_button_n;
  logic       i_sw_reset;
  logic [2:0] o_reset_n;
  logic       o_busy;
  logic [1:0] o_cause;

  int n_tests = 0;
  int n_fail  = 0;

  reset_sequencer dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_button_n (i_button_n),
    .i_sw_reset (i_sw_reset),
    .o_reset_n  (o_reset_n),
    .o_busy     (o_busy),
    .o_cause    (o_cause)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string      name;
    logic       sw;
    logic       btn;
    int         n;
    logic [2:0] rst;
    logic       busy;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic sw, input logic btn, input int n,
                              input logic [2:0] rst, input logic busy, input logic [1:0] cause);
    vec_t v;
    v.name = name; v.sw = sw; v.btn = btn; v.n = n;
    v.rst = rst; v.busy = busy; v.cause = cause;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [2:0] rst, input logic busy,
                       input logic [1:0] cause);
    n_tests++;
    if (o_reset_n !== rst || o_busy !== busy || o_cause !== cause) begin
      n_fail++;
      $display("FAIL %s: got rst=%b busy=%b cause=%b, expected rst=%b busy=%b cause=%b",
               name, o_reset_n, o_busy, o_cause, rst, busy, cause);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n  = 1'b0;
    i_button_n = 1'b1;
    i_sw_reset = 1'b0;

    // Power-up from external reset
    add("pu_e11",   0, 1, 11, 3'b000, 1, 2'b00);
    add("pu_e12",   0, 1,  1, 3'b001, 1, 2'b00);
    add("pu_e15",   0, 1,  3, 3'b001, 1, 2'b00);
    add("pu_e16",   0, 1,  1, 3'b011, 1, 2'b00);
    add("pu_e19",   0, 1,  3, 3'b011, 1, 2'b00);
    add("pu_e20",   0, 1,  1, 3'b111, 0, 2'b00);
    add("run_idle", 0, 1,  5, 3'b111, 0, 2'b00);
    // Software request from RUN
    add("sw_req",   1, 1,  1, 3'b000, 1, 2'b10);
    add("sw_n9",    0, 1,  9, 3'b000, 1, 2'b10);
    add("sw_n10",   0, 1,  1, 3'b001, 1, 2'b10);
    add("sw_n14",   0, 1,  4, 3'b011, 1, 2'b10);
    add("sw_n18",   0, 1,  4, 3'b111, 0, 2'b10);
    // Short button bounce is filtered
    add("bounce",     0, 0,  5, 3'b111, 0, 2'b10);
    add("bounce_rel", 0, 1, 12, 3'b111, 0, 2'b10);
    // Held button
    add("hold_e9",   0, 0,  9, 3'b111, 0, 2'b10);
    add("hold_e10",  0, 0,  1, 3'b000, 1, 2'b01);
    add("hold_long", 0, 0, 20, 3'b000, 1, 2'b01);
    add("rel_e19",   0, 1, 19, 3'b000, 1, 2'b01);
    add("rel_e20",   0, 1,  1, 3'b001, 1, 2'b01);
    add("rel_e24",   0, 1,  4, 3'b011, 1, 2'b01);
    add("rel_e28",   0, 1,  4, 3'b111, 0, 2'b01);
    // Software request while releasing restarts from HOLD
    add("sr_start",  1, 1,  1, 3'b000, 1, 2'b10);
    add("sr_e10",    0, 1, 10, 3'b001, 1, 2'b10);
    add("sr_hit",    1, 1,  1, 3'b000, 1, 2'b10);
    add("sr_e9",     0, 1,  9, 3'b000, 1, 2'b10);
    add("sr_e10b",   0, 1,  1, 3'b001, 1, 2'b10);
    add("sr_e18",    0, 1,  8, 3'b111, 0, 2'b10);

    #12;
    check("reset_state", 3'b000, 1, 2'b00);
    step(2);
    check("reset_clocked", 3'b000, 1, 2'b00);
    @(posedge i_clk);
    #2 i_reset_n = 1'b1;

    foreach (tbl[i]) begin
      i_sw_reset = tbl[i].sw;
      i_button_n = tbl[i].btn;
      step(tbl[i].n);
      check(tbl[i].name, tbl[i].rst, tbl[i].busy, tbl[i].cause);
    end
    i_sw_reset = 1'b0;

    // Press event and software request on the same edge
    i_button_n = 1'b0;
    step(9);
    check("sim_pre", 3'b111, 0, 2'b10);
    i_sw_reset = 1'b1;
    step(1);
    check("sim_cause", 3'b000, 1, 2'b01);
    i_sw_reset = 1'b0;
    i_button_n = 1'b1;
    step(19);
    check("sim_e19", 3'b000, 1, 2'b01);
    step(1);
    check("sim_e20", 3'b001, 1, 2'b01);
    step(8);
    check("sim_done", 3'b111, 0, 2'b01);

    // External reset pulsed between clock edges
    @(posedge i_clk);
    #3 i_reset_n = 1'b0;
    #1;
    check("async_assert", 3'b000, 1, 2'b00);
    #1 i_reset_n = 1'b1;
    step(11);
    check("async_e11", 3'b000, 1, 2'b00);
    step(1);
    check("async_e12", 3'b001, 1, 2'b00);
    step(8);
    check("async_e20", 3'b111, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-channel reset sequencer: the next-generation replacement for the single-output power-on reset counter. It generates NUM_CHANNELS active-low reset outputs, which are asserted together and released in staggered order, e.g. clock/bus logic first, then memory interface, then the Z80. Reset can come from three sources: an external asynchronous reset, a debounced manual button, or a synchronous software request. The block sits at the top level between board inputs and all other blocks.

## Interface
- NUM_CHANNELS, 3, number of reset outputs (≥1); channel 0 is released first.
- HOLD_CYCLES, 10, cycles all channels stay asserted before channel 0 is released (≥1).
- STAGGER_CYCLES, 4, cycles between release of channel k-1 and channel k (≥1).
- DEBOUNCE_CYCLES, 8, consecutive stable synchronised samples needed to change the debounced button level (≥1).
- SYNC_STAGES, 2, flop stages on i_reset_n deassertion and on i_button_n (≥2).
- CNT_WIDTH, 8, shared counter width; must hold max(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES).
- i_clk  in  1  system clock; all state is on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset, e.g. from PLL lock or board supervisor. Assertion takes effect immediately; deassertion is synchronised internally.
- i_button_n  in  1  manual reset button, active-low, asynchronous and bouncy.
- i_sw_reset  in  1  synchronous active-high software reset request, sampled every cycle.
- o_reset_n  out  NUM_CHANNELS  per-channel active-low resets, registered.
- o_busy  out  1  high while any channel is asserted.
- o_cause  out  2  last reset cause: 00 external, 01 button, 10 software; 11 is never driven.

## Operation
- States: HOLD, RELEASE, RUN.
- i_reset_n low (async):
  - o_reset_n = 0 on all bits, o_busy = 1, o_cause = 00.
  - State HOLD, counter 0, channel index 0.
  - Synchroniser chain cleared; debounced button level set to 1 (released).
- rst_sync is the last stage of the SYNC_STAGES chain clocking in 1. While rst_sync = 0, the FSM stays in HOLD with counter 0.
- HOLD:
  - Counter increments on each edge with rst_sync = 1 and debounced button high.
  - While the debounced button is low, the counter is held at 0. Holding the button keeps all resets asserted.
  - On the edge where counter == HOLD_CYCLES-1: o_reset_n[0] rises and the counter clears.
  - That edge moves to RELEASE, or to RUN if NUM_CHANNELS == 1.
- RELEASE:
  - Counter increments each edge.
  - On the edge where counter == STAGGER_CYCLES-1: release the next channel and clear the counter.
  - On the edge releasing channel NUM_CHANNELS-1: go to RUN; o_busy falls on the same edge.
- RUN: all outputs high, counter idle.
- Button path:
  - i_button_n passes through SYNC_STAGES flops (preset to 1 by reset).
  - The debounce counter counts consecutive synchronised samples that differ from the debounced level. It clears on any sample equal to the debounced level.
  - At DEBOUNCE_CYCLES samples the debounced level toggles. A 1→0 toggle is a press event.
- Reset request = press event OR i_sw_reset, accepted in any state:
  - On that edge: all o_reset_n bits go to 0, o_busy = 1, state HOLD, counter 0, channel index 0.
  - o_cause = 01 if the press event is present (button wins a simultaneous request), else 10.
  - A request during HOLD or RELEASE restarts the sequence from HOLD.
- Channels never release out of order. Once the sequence starts, each o_reset_n bit changes at most once (0→1) until the next request.

## Timing
- Released outputs are monotonic: o_reset_n[k] = 1 implies o_reset_n[j] = 1 for all j < k.
- External reset release to channel 0: edge SYNC_STAGES + HOLD_CYCLES. Edge 1 is the first edge with i_reset_n high.
- Channel k releases STAGGER_CYCLES edges after channel k-1.
- Software request sampled at edge N:
  - Outputs low after edge N.
  - Channel 0 high after edge N + HOLD_CYCLES.
- Button press: i_button_n is low continuously from before edge 1. The press event and output assertion occur at edge SYNC_STAGES + DEBOUNCE_CYCLES.
- i_reset_n assertion clears outputs combinationally through the async reset, with no clock required.

## Test plan
- Power-up with defaults; i_reset_n rises before edge 1 -> o_reset_n = 001 after edge 12, 011 after edge 16, 111 after edge 20; o_busy falls at edge 20; o_cause = 00.
- In RUN, one-cycle i_sw_reset at edge N -> o_reset_n = 000 after edge N, o_cause = 10; 001 after edge N+10, 111 after edge N+18.
- In RUN, i_button_n low for 5 cycles then high -> no change. Held low continuously -> 000 at edge 10, o_cause = 01. Stays 000 while held; release sequence starts 10 edges after the debounced level returns high.
- i_sw_reset while o_reset_n = 001 (RELEASE) -> immediate 000; full HOLD restart, with 001 reached HOLD_CYCLES edges later.
- Press event and i_sw_reset on the same edge -> o_cause = 01, a single restart.
- i_reset_n pulsed low mid-RUN, between clock edges -> o_reset_n = 000 and o_busy = 1 before the next edge; o_cause = 00; sequence repeats as in power-up.
